// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared constants and types for the interrupt controller:
//               CSR address map, FSM state encoding, spurious-cause code and
//               the fixed interrupt vector address.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // CSR address map
    localparam logic [1:0] CSR_MASK  = 2'd0;
    localparam logic [1:0] CSR_PEND  = 2'd1;
    localparam logic [1:0] CSR_EPC   = 2'd2;
    localparam logic [1:0] CSR_CAUSE = 2'd3;

    // Controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Cause reported when the acknowledged request has no unmasked source left
    localparam logic [15:0] CAUSE_SPURIOUS = 16'hFFFF;

    // Address the PC vectors to when it takes irq
    localparam logic [15:0] VECTOR_ADDR = 16'h0001;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Combinational priority encoder, lowest index wins.
// Ports       : req   - request vector (N bits)
//               idx   - index of the lowest set bit of req (0 when none)
//               valid - at least one bit of req is set
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top down so the last match, the lowest index, wins.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

    assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Interrupt controller. Latches rising edges on the sources,
//               masks and prioritises them, holds irq until the core takes
//               the vector, records return address and cause, then blocks
//               further requests until iret.
// Ports       : clk, rst (async, active-low)
//               src        - edge-triggered interrupt sources
//               irq        - registered request to the core
//               irq_ack    - core takes the vector this cycle
//               ret_addr   - return address captured on irq_ack
//               iret       - return-from-interrupt pulse
//               epc        - saved return address
//               csr_we/csr_addr/csr_wdata/csr_rdata - CSR access
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int AW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NSRC-1:0] src,
    output logic          irq,
    input  logic          irq_ack,
    input  logic [AW-1:0] ret_addr,
    input  logic          iret,
    output logic [AW-1:0] epc,
    input  logic          csr_we,
    input  logic [1:0]    csr_addr,
    input  logic [AW-1:0] csr_wdata,
    output logic [AW-1:0] csr_rdata
);

    localparam int c_IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    state_t          r_state;
    state_t          w_next;
    logic [NSRC-1:0] r_src_prev;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_mask;
    logic [AW-1:0]   r_epc;
    logic [AW-1:0]   r_cause;

    logic [NSRC-1:0] w_edge;
    logic [NSRC-1:0] w_active;
    logic [NSRC-1:0] w_w1c;
    logic [NSRC-1:0] w_ack_clr;
    logic [c_IW-1:0] w_idx;
    logic            w_valid;
    logic            w_take;

    assign w_edge   = src & ~r_src_prev;
    // Uses the registered mask, so a same-cycle MASK write does not affect
    // the cause being captured.
    assign w_active = r_pend & r_mask;
    assign w_take   = irq_ack && (r_state == REQ);
    assign w_w1c    = (csr_we && csr_addr == CSR_PEND) ? csr_wdata[NSRC-1:0] : '0;

    irq_prio_enc #(
        .N  (NSRC),
        .IW (c_IW)
    ) u_prio (
        .req   (w_active),
        .idx   (w_idx),
        .valid (w_valid)
    );

    always_comb begin
        w_ack_clr = '0;
        if (w_take && w_valid) w_ack_clr[w_idx] = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|w_active) w_next = REQ;
            REQ:     if (irq_ack)   w_next = SERVICE;
            SERVICE: if (iret)      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src_prev <= '0;
            r_pend     <= '0;
            r_mask     <= '0;
            r_epc      <= '0;
            r_cause    <= '0;
        end else begin
            r_src_prev <= src;
            // A new edge beats any clear on the same bit.
            r_pend     <= (r_pend & ~(w_w1c | w_ack_clr)) | w_edge;
            if (csr_we && csr_addr == CSR_MASK) r_mask <= csr_wdata[NSRC-1:0];
            if (w_take) begin
                r_epc   <= ret_addr;
                r_cause <= w_valid ? AW'(w_idx) : AW'(CAUSE_SPURIOUS);
            end else if (csr_we && csr_addr == CSR_EPC) begin
                r_epc <= csr_wdata;
            end
        end
    end

    // irq is a decode of the state register, so it is glitch-free and registered.
    assign irq = (r_state == REQ);
    assign epc = r_epc;

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MASK:  csr_rdata = AW'(r_mask);
            CSR_PEND:  csr_rdata = AW'(r_pend);
            CSR_EPC:   csr_rdata = r_epc;
            CSR_CAUSE: csr_rdata = r_cause;
            default:   csr_rdata = '0;
        endcase
    end

endmodule
`default_nettype wire
